// File: rtl/aui_lane_sync_checker.sv
`default_nettype none
// ============================================================================
// Module      : aui_lane_sync_checker
// Description : Per-lane alignment-marker lock checker for a multi-lane AUI.
//               Each physical lane hunts for the alignment-marker body,
//               verifies it recurs every AM_PERIOD valid words with a stable
//               logical lane id, and then monitors the lane while locked.
//               It reports lock state, the captured lane id and a saturating
//               bad-marker count.
// Revision    : 1.0 - initial release
// ============================================================================
module aui_lane_sync_checker #(
    parameter int                    NUM_LANES  = 16,
    parameter int                    WORD_WIDTH = 64,
    parameter logic [WORD_WIDTH-9:0] AM_PATTERN = 56'hC168_21F4_3E97_DE,
    parameter int                    AM_PERIOD  = 1024,
    parameter int                    LOCK_COUNT = 3,
    parameter int                    MISS_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES*WORD_WIDTH-1:0] i_data,
    input  logic [NUM_LANES-1:0]            i_valid,
    output logic [NUM_LANES-1:0]            o_lock,
    output logic                            o_all_locked,
    output logic [NUM_LANES*8-1:0]          o_lane_id,
    output logic [NUM_LANES*16-1:0]         o_am_err_cnt
);

    localparam int c_POS_W  = $clog2(AM_PERIOD);
    localparam int c_GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int c_MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [c_POS_W-1:0]  c_POS_LAST  = c_POS_W'(AM_PERIOD - 1);
    localparam logic [c_POS_W-1:0]  c_POS_ONE   = c_POS_W'(1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_ONE  = c_GOOD_W'(1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_COUNT - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_LIMIT - 1);

    localparam logic [1:0] c_HUNT   = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    generate
        for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
            logic [1:0]            r_state;
            logic [1:0]            w_state_nxt;
            logic [c_POS_W-1:0]    r_pos;
            logic [c_POS_W-1:0]    w_pos_nxt;
            logic [c_POS_W-1:0]    w_pos_inc;
            logic [c_GOOD_W-1:0]   r_good;
            logic [c_GOOD_W-1:0]   w_good_nxt;
            logic [c_MISS_W-1:0]   r_miss;
            logic [c_MISS_W-1:0]   w_miss_nxt;
            logic [7:0]            r_lane_id;
            logic [7:0]            w_lane_id_nxt;
            logic [15:0]           r_err_cnt;
            logic [15:0]           w_err_cnt_nxt;
            logic [15:0]           w_err_inc;
            logic                  r_lock;
            logic [WORD_WIDTH-1:0] w_word;
            logic                  w_is_am;
            logic                  w_good_am;
            logic                  w_slot;

            assign w_word    = i_data[n*WORD_WIDTH +: WORD_WIDTH];
            assign w_is_am   = i_valid[n] && (w_word[WORD_WIDTH-1:8] == AM_PATTERN);
            // A good marker must carry the id captured when the hunt succeeded
            assign w_good_am = w_is_am && (w_word[7:0] == r_lane_id);
            // Position 0 is where the next marker is expected
            assign w_slot    = (r_pos == '0);
            assign w_pos_inc = (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
            assign w_err_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

            // State register: all lane state, reset to HUNT with cleared counters
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= c_HUNT;
                    r_pos     <= '0;
                    r_good    <= '0;
                    r_miss    <= '0;
                    r_lane_id <= '0;
                    r_err_cnt <= '0;
                    r_lock    <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_pos     <= w_pos_nxt;
                    r_good    <= w_good_nxt;
                    r_miss    <= w_miss_nxt;
                    r_lane_id <= w_lane_id_nxt;
                    r_err_cnt <= w_err_cnt_nxt;
                    r_lock    <= (w_state_nxt == c_LOCKED);
                end
            end

            // Next-state logic: only valid words advance the lane; idle cycles hold
            always_comb begin
                w_state_nxt   = r_state;
                w_pos_nxt     = r_pos;
                w_good_nxt    = r_good;
                w_miss_nxt    = r_miss;
                w_lane_id_nxt = r_lane_id;
                w_err_cnt_nxt = r_err_cnt;
                if (i_valid[n]) begin
                    case (r_state)
                        c_HUNT: begin
                            if (w_is_am) begin
                                w_lane_id_nxt = w_word[7:0];
                                w_pos_nxt     = c_POS_ONE;
                                w_good_nxt    = c_GOOD_ONE;
                                if (LOCK_COUNT == 1) begin
                                    w_state_nxt = c_LOCKED;
                                    w_miss_nxt  = '0;
                                end else begin
                                    w_state_nxt = c_VERIFY;
                                end
                            end
                        end
                        c_VERIFY: begin
                            w_pos_nxt = w_pos_inc;
                            // Off-slot words, stray markers included, are ignored
                            if (w_slot) begin
                                if (w_good_am) begin
                                    w_good_nxt = r_good + 1'b1;
                                    if (r_good == c_GOOD_LAST) begin
                                        w_state_nxt = c_LOCKED;
                                        w_miss_nxt  = '0;
                                    end
                                end else begin
                                    w_state_nxt = c_HUNT;
                                    w_pos_nxt   = '0;
                                    w_good_nxt  = '0;
                                end
                            end
                        end
                        c_LOCKED: begin
                            w_pos_nxt = w_pos_inc;
                            if (w_slot) begin
                                if (w_good_am) begin
                                    w_miss_nxt = '0;
                                end else begin
                                    w_err_cnt_nxt = w_err_inc;
                                    if (r_miss == c_MISS_LAST) begin
                                        // Lane id and error count survive loss of lock
                                        w_state_nxt = c_HUNT;
                                        w_pos_nxt   = '0;
                                        w_good_nxt  = '0;
                                        w_miss_nxt  = '0;
                                    end else begin
                                        w_miss_nxt = r_miss + 1'b1;
                                    end
                                end
                            end
                        end
                        default: begin
                            w_state_nxt = c_HUNT;
                            w_pos_nxt   = '0;
                            w_good_nxt  = '0;
                            w_miss_nxt  = '0;
                        end
                    endcase
                end
            end

            // Outputs: driven straight from lane registers
            assign o_lock[n]              = r_lock;
            assign o_lane_id[n*8 +: 8]    = r_lane_id;
            assign o_am_err_cnt[n*16 +: 16] = r_err_cnt;
        end
    endgenerate

    logic r_all_locked;

    // Aggregate lock lags the per-lane flags by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= &o_lock;
        end
    end

    assign o_all_locked = r_all_locked;

endmodule
`default_nettype wire

// File: tb/tb_aui_lane_sync_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_aui_lane_sync_checker
// Description : Directed self-checking bench for aui_lane_sync_checker with
//               4 lanes, 8-word marker period, lock after 3, loss after 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aui_lane_sync_checker;

    localparam int          c_LANES = 4;
    localparam int          c_WW    = 64;
    localparam logic [55:0] c_AM    = 56'hC168_21F4_3E97_DE;

    logic                      clk;
    logic                      rst;
    logic [c_LANES*c_WW-1:0]   i_data;
    logic [c_LANES-1:0]        i_valid;
    logic [c_LANES-1:0]        o_lock;
    logic                      o_all_locked;
    logic [c_LANES*8-1:0]      o_lane_id;
    logic [c_LANES*16-1:0]     o_am_err_cnt;

    int         checks;
    int         failures;
    int         fp [c_LANES];
    logic [7:0] ids [c_LANES];
    logic [25:0] stall;
    int         nstall;
    int         k;

    aui_lane_sync_checker #(
        .NUM_LANES  (c_LANES),
        .WORD_WIDTH (c_WW),
        .AM_PATTERN (c_AM),
        .AM_PERIOD  (8),
        .LOCK_COUNT (3),
        .MISS_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_lock       (o_lock),
        .o_all_locked (o_all_locked),
        .o_lane_id    (o_lane_id),
        .o_am_err_cnt (o_am_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: each valid lane sends a marker at its slot (unless corrupted)
    // or when a stray is requested, filler otherwise; idle lanes carry a
    // marker-shaped word that must be ignored.
    task automatic cyc(input logic [3:0] v, input logic [3:0] corrupt, input logic [3:0] stray);
        logic [63:0] w;
        for (int n = 0; n < c_LANES; n++) begin
            if (v[n]) begin
                if (fp[n] == 0 && corrupt[n])
                    w = {c_AM ^ 56'h1, ids[n]};
                else if (fp[n] == 0 || stray[n])
                    w = {c_AM, ids[n]};
                else
                    w = 64'h0123_4567_89AB_CD00 | 64'(n);
                fp[n] = (fp[n] == 7) ? 0 : fp[n] + 1;
            end else begin
                w = {c_AM, 8'hAA};
            end
            i_data[n*c_WW +: c_WW] = w;
        end
        i_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [3:0] corrupt);
        cyc(4'hF, corrupt, 4'h0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cyc(4'hF, 4'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < c_LANES; n++) fp[n] = 0;
    endtask

    task automatic std_ids();
        for (int n = 0; n < c_LANES; n++) ids[n] = 8'(n);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        i_valid  = '0;
        i_data   = '0;
        std_ids();

        // Reset state
        do_reset();
        chk("rst_lock", 64'(o_lock), 64'h0);
        chk("rst_all", 64'(o_all_locked), 64'h0);
        chk("rst_id", 64'(o_lane_id), 64'h0);
        chk("rst_err", o_am_err_cnt, 64'h0);

        // Normal lock on all lanes, ids 0..3
        slot(4'h0); fill(7);
        slot(4'h0);
        chk("lock_after2", 64'(o_lock), 64'h0);
        fill(7);
        slot(4'h0);
        chk("lock_after3", 64'(o_lock), 64'hF);
        chk("all_same_cycle", 64'(o_all_locked), 64'h0);
        fill(1);
        chk("all_next_cycle", 64'(o_all_locked), 64'h1);
        fill(6);
        chk("ids_normal", 64'(o_lane_id), 64'h0302_0100);
        chk("err_normal", o_am_err_cnt, 64'h0);

        // Lane 0: one corrupted marker, then a good one
        slot(4'h1);
        chk("err_single", o_am_err_cnt, 64'h1);
        chk("lock_single", 64'(o_lock), 64'hF);
        fill(7);
        slot(4'h0);
        chk("err_after_good", o_am_err_cnt, 64'h1);
        fill(7);

        // Lane 0: four consecutive corrupted markers
        slot(4'h1); fill(7);
        slot(4'h1); fill(7);
        slot(4'h1);
        chk("lock_miss3", 64'(o_lock), 64'hF);
        chk("err_miss3", o_am_err_cnt, 64'h4);
        fill(7);
        slot(4'h1);
        chk("lock_miss4", 64'(o_lock), 64'hE);
        chk("err_miss4", o_am_err_cnt, 64'h5);
        chk("all_miss4_same", 64'(o_all_locked), 64'h1);
        fill(1);
        chk("all_miss4_next", 64'(o_all_locked), 64'h0);
        fill(1);

        // Stray marker at position 3 on locked lane 1
        cyc(4'hF, 4'h0, 4'h2);
        chk("stray_err", o_am_err_cnt, 64'h5);
        chk("stray_lock", 64'(o_lock), 64'hE);
        chk("lost_id_hold", 64'(o_lane_id), 64'h0302_0100);
        fill(4);

        // Relock lane 0 while others stay locked
        slot(4'h0); fill(7);
        slot(4'h0);
        chk("relock0_after2", 64'(o_lock), 64'hE);
        fill(7);
        slot(4'h0);
        chk("relock0_after3", 64'(o_lock), 64'hF);
        chk("relock0_err", o_am_err_cnt, 64'h5);
        fill(1);
        chk("relock0_all", 64'(o_all_locked), 64'h1);

        // Reset pulse while locked with nonzero error count, markers present
        rst = 1'b1;
        cyc(4'hF, 4'h0, 4'hF);
        rst = 1'b0;
        for (int n = 0; n < c_LANES; n++) fp[n] = 0;
        chk("rstp_lock", 64'(o_lock), 64'h0);
        chk("rstp_all", 64'(o_all_locked), 64'h0);
        chk("rstp_id", 64'(o_lane_id), 64'h0);
        chk("rstp_err", o_am_err_cnt, 64'h0);
        slot(4'h0); fill(7);
        slot(4'h0); fill(7);
        slot(4'h0);
        chk("rstp_relock", 64'(o_lock), 64'hF);

        // Lanes 1 and 2 swapped
        do_reset();
        ids[0] = 8'd0; ids[1] = 8'd2; ids[2] = 8'd1; ids[3] = 8'd3;
        slot(4'h0); fill(7);
        slot(4'h0); fill(7);
        slot(4'h0);
        chk("swap_lock", 64'(o_lock), 64'hF);
        fill(1);
        chk("swap_all", 64'(o_all_locked), 64'h1);
        chk("swap_ids", 64'(o_lane_id), 64'h0301_0200);
        chk("swap_err", o_am_err_cnt, 64'h0);

        // Lane 0 id changes during VERIFY: back to HUNT, relocks on new id
        do_reset();
        std_ids();
        slot(4'h0); fill(7);
        ids[0] = 8'd1;
        slot(4'h0); fill(7);
        slot(4'h0);
        chk("idchg_lock3", 64'(o_lock), 64'hE);
        fill(7);
        slot(4'h0);
        chk("idchg_lock4", 64'(o_lock), 64'hE);
        fill(7);
        slot(4'h0);
        chk("idchg_lock5", 64'(o_lock), 64'hF);
        chk("idchg_id", 64'(o_lane_id), 64'h0302_0101);

        // Lane 2 stalled for 5 random cycles between markers
        do_reset();
        std_ids();
        stall  = '0;
        nstall = 0;
        while (nstall < 5) begin
            k = $urandom_range(15, 1);
            if (!stall[k]) begin
                stall[k] = 1'b1;
                nstall++;
            end
        end
        for (int c = 0; c < 26; c++) begin
            cyc(stall[c] ? 4'b1011 : 4'hF, 4'h0, 4'h0);
            if (c == 16) chk("stall_c16", 64'(o_lock), 64'hB);
            if (c == 20) chk("stall_c20", 64'(o_lock), 64'hB);
            if (c == 21) begin
                chk("stall_c21", 64'(o_lock), 64'hF);
                chk("stall_all_c21", 64'(o_all_locked), 64'h0);
            end
            if (c == 22) chk("stall_all_c22", 64'(o_all_locked), 64'h1);
        end
        chk("stall_err", o_am_err_cnt, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aui_lane_sync_checker.md
AUI_LANE_SYNC_CHECKER -- requirements
Module: aui_lane_sync_checker

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16, number of physical lanes checked (1..32).
REQ-002 SHALL have parameter WORD_WIDTH, default 64, bits per lane word per cycle (>=16).
REQ-003 SHALL have parameter AM_PATTERN, default 56'hC168_21F4_3E97_DE (WORD_WIDTH-8 bits), alignment-marker body.
REQ-004 SHALL have parameter AM_PERIOD, default 1024, valid words per lane from one marker to the next, marker included (>=2).
REQ-005 SHALL have parameter LOCK_COUNT, default 3, consecutive good markers to lock (>=1).
REQ-006 SHALL have parameter MISS_LIMIT, default 4, consecutive bad markers to lose lock (>=1).
REQ-007 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port i_data, input, NUM_LANES*WORD_WIDTH, lane n word at [n*WORD_WIDTH +: WORD_WIDTH].
REQ-010 SHALL have port i_valid, input, NUM_LANES, per-lane word qualifier.
REQ-011 SHALL have port o_lock, output, NUM_LANES, per-lane locked flag.
REQ-012 SHALL have port o_all_locked, output, 1, AND of all o_lock bits, registered.
REQ-013 SHALL have port o_lane_id, output, NUM_LANES*8, logical lane id captured per physical lane.
REQ-014 SHALL have port o_am_err_cnt, output, NUM_LANES*16, per-lane bad-marker count while locked.

Function
REQ-015 Marker on lane n SHALL mean i_valid[n]=1 and word[WORD_WIDTH-1:8]==AM_PATTERN; word[7:0] is its lane id.
REQ-016 Each lane SHALL run an independent FSM with states HUNT, VERIFY, LOCKED, plus a position counter 0..AM_PERIOD-1.
REQ-017 Cycles with i_valid[n]=0 SHALL leave all lane-n state, counters and outputs unchanged.
REQ-018 In VERIFY/LOCKED the counter SHALL increment on each valid word, wrap from AM_PERIOD-1 to 0; position 0 is the expected-marker slot.
REQ-019 HUNT: marker -> VERIFY, counter:=1, good:=1, o_lane_id[n]:=word[7:0]; non-marker -> stay HUNT.
REQ-020 VERIFY, expected slot: marker with id equal to captured id -> good+1; good reaching LOCK_COUNT -> LOCKED, miss:=0.
REQ-021 VERIFY, expected slot: non-marker or id mismatch -> HUNT; non-slot words, including stray markers, ignored.
REQ-022 LOCK_COUNT=1 SHALL lock on the first marker seen in HUNT (HUNT -> LOCKED directly).
REQ-023 LOCKED, expected slot: matching marker -> miss:=0; otherwise miss+1 and o_am_err_cnt[n]+1, saturating at 16'hFFFF.
REQ-024 LOCKED: miss reaching MISS_LIMIT -> HUNT; o_lock[n] falls; o_lane_id[n] and o_am_err_cnt[n] hold.
REQ-025 o_lock[n] SHALL be 1 exactly while lane n is in LOCKED, registered, rising the cycle after the completing marker.
REQ-026 o_all_locked SHALL follow o_lock by one cycle (two cycles after the last lane's locking marker).
REQ-027 Lanes SHALL be fully independent; lane swaps are reported via o_lane_id, not flagged as errors.

Reset
REQ-028 rst=1 at a clock edge SHALL force every lane to HUNT, counters/good/miss to 0, o_lock=0, o_all_locked=0, o_lane_id=0, o_am_err_cnt=0.
REQ-029 rst SHALL win over any simultaneous valid word or marker, including mid-lock; first sampling resumes the edge after rst falls.

Verification (NUM_LANES=4, AM_PERIOD=8, LOCK_COUNT=3, MISS_LIMIT=4 unless stated)
REQ-030 Bench SHALL cover: markers with ids 0..3 every 8 valid words on lanes 0..3 -> each o_lock 1 the cycle after its 3rd marker, o_all_locked one cycle later, o_lane_id={3,2,1,0}.
REQ-031 Bench SHALL cover: lanes 1 and 2 swapped (ids 2 on lane 1, 1 on lane 2) -> all locked, o_lane_id lane1=2, lane2=1, err counts 0.
REQ-032 Bench SHALL cover: locked lane 0, one corrupted marker then good -> o_am_err_cnt[0]=1, o_lock[0] stays 1; four consecutive corrupted -> err=5, o_lock[0] falls after 4th, o_all_locked falls next cycle.
REQ-033 Bench SHALL cover: i_valid[2] low for 5 random cycles between markers -> lane 2 lock timing shifts by exactly the stalled cycles, no errors.
REQ-034 Bench SHALL cover: VERIFY lane sees id change (0 then 1 at slot) -> returns to HUNT, o_lock stays 0; stray marker at position 3 while locked -> ignored, err unchanged.
REQ-035 Bench SHALL cover: rst pulsed 1 cycle while all locked with nonzero err counts -> next cycle all outputs 0, relock after 3 markers per lane.
